// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite slave over a word-addressed register-array SRAM; independent write (AW/W/B) and read (AR/R) FSMs.
// Optional macro AXIL_SLVERR_EN: out-of-range accesses answer SLVERR instead of wrapping modulo DEPTH_WORDS.
module axi4lite_sram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        rready,
  output logic [1:0]  rresp
);

  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  logic             alive_q, alive_d;

  w_state_e         w_state_q, w_state_d;
  logic             aw_held_q, aw_held_d;
  logic             w_held_q, w_held_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;

  r_state_e         r_state_q, r_state_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic             mem_we;

  logic [31:0]      aw_off, ar_off;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic             w_err, r_err;
  logic             aw_hs, w_hs, ar_hs;
  logic             unused_ok;

  // Offsets wrap naturally; only the word-index bits select the array entry.
  assign aw_off = awaddr_q - BASE_ADDR;
  assign ar_off = araddr - BASE_ADDR;
  assign w_idx  = aw_off[IDX_W+1:2];
  assign r_idx  = ar_off[IDX_W+1:2];

`ifdef AXIL_SLVERR_EN
  // A 33-bit difference puts addresses below BASE_ADDR far above the window.
  function automatic logic addr_in_range(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return off < (33'(DEPTH_WORDS) << 2);
  endfunction

  assign w_err = ~addr_in_range(awaddr_q);
  assign r_err = ~addr_in_range(araddr);
`else
  assign w_err = 1'b0;
  assign r_err = 1'b0;
`endif

  assign unused_ok = ^{awprot, arprot, aw_off[1:0], ar_off[1:0],
                       aw_off[31:IDX_W+2], ar_off[31:IDX_W+2]};

  assign awready = alive_q & ~aw_held_q & ~bvalid_q;
  assign wready  = alive_q & ~w_held_q & ~bvalid_q;
  assign arready = alive_q & ~rvalid_q;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;

  assign alive_d = 1'b1;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if (aw_held_d && w_held_d) w_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        mem_we    = ~w_err;
        bvalid_d  = 1'b1;
        bresp_d   = w_err ? RESP_SLVERR : RESP_OKAY;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // The array read here sees only writes from earlier edges, giving read-old-data on collisions.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rvalid_d  = 1'b1;
          rdata_d   = r_err ? 32'h0 : mem[r_idx];
          rresp_d   = r_err ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q   <= 1'b0;
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
    end else begin
      alive_q   <= alive_d;
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // NOTE: the array is deliberately not reset; a reset port would stop it mapping onto RAM.
  // A commit only happens from W_COMMIT, which reset forces away, so no partial write survives.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_sram_slave.sv
// Self-checking bench for axi4lite_sram_slave: directed corner sequences, a vector table,
// and randomized traffic against a byte-merge reference model. Honours AXIL_SLVERR_EN.
module tb_axi4lite_sram_slave;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned RND_WORDS = 16;
  localparam logic [31:0] RND_BASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [1:0]  bresp;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [1:0]  rresp;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] ref_mem [RND_WORDS];

  axi4lite_sram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rresp(rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte-lane merge straight from the strobe rule.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp);
    bit aw_done, w_done, aw_fire, w_fire;
    int c;
    aw_done = 0; w_done = 0; c = 0;
    awaddr = addr; wdata = data; wstrb = strb; bready = 1'b0;
    while (!(aw_done && w_done) && c < 60) begin
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      step();
      aw_done = aw_done || aw_fire;
      w_done  = w_done || w_fire;
      c++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check1("aw_w_handshake", aw_done && w_done, 1'b1);
    repeat (b_dly) step();
    c = 0;
    while (!bvalid && c < 60) begin step(); c++; end
    check1("b_valid_seen", bvalid, 1'b1);
    resp = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    bit done;
    int c;
    done = 0; c = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    while (!done && c < 60) begin
      done = arready;
      step();
      c++;
    end
    arvalid = 1'b0;
    check1("ar_handshake", done, 1'b1);
    c = 0;
    while (!rvalid && c < 60) begin step(); c++; end
    check1("r_valid_seen", rvalid, 1'b1);
    repeat (r_dly) step();
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  rsp;

    vecs[0] = '{32'h40, 32'h0123_4567, 4'hF, 32'h0123_4567};
    vecs[1] = '{32'h40, 32'hAABB_CCDD, 4'h2, 32'h0123_CC67};
    vecs[2] = '{32'h40, 32'hAABB_CCDD, 4'h8, 32'hAA23_CC67};
    vecs[3] = '{32'h40, 32'hFFFF_FFFF, 4'h0, 32'hAA23_CC67};
    vecs[4] = '{32'h44, 32'h5A5A_5A5A, 4'hF, 32'h5A5A_5A5A};
    vecs[5] = '{32'h47, 32'h0000_0000, 4'h3, 32'h5A5A_0000};
    vecs[6] = '{32'hFFC, 32'h1357_9BDF, 4'hF, 32'h1357_9BDF};

    // Reset release
    repeat (3) step();
    check1("rst_awready", awready, 1'b0);
    check1("rst_wready", wready, 1'b0);
    check1("rst_arready", arready, 1'b0);
    check1("rst_bvalid", bvalid, 1'b0);
    check1("rst_rvalid", rvalid, 1'b0);
    rst = 1'b0;
    check1("pre_alive_awready", awready, 1'b0);
    step();
    check1("alive_awready", awready, 1'b1);
    check1("alive_wready", wready, 1'b1);
    check1("alive_arready", arready, 1'b1);

    // AW+W same cycle: bvalid two edges after presenting, then readback
    awaddr = 32'h10; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check1("t2_bvalid_edge1", bvalid, 1'b0);
    step();
    check1("t2_bvalid_edge2", bvalid, 1'b1);
    check("t2_bresp", 32'(bresp), 32'h0);
    step();
    bready = 1'b0;
    check1("t2_bvalid_cleared", bvalid, 1'b0);
    check1("t2_awready_back", awready, 1'b1);
    araddr = 32'h10; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    check1("t2_rvalid", rvalid, 1'b1);
    check("t2_rdata", rdata, 32'hDEAD_BEEF);
    check("t2_rresp", 32'(rresp), 32'h0);
    check1("t2_arready_low", arready, 1'b0);
    rready = 1'b1;
    step();
    rready = 1'b0;
    check1("t2_rvalid_cleared", rvalid, 1'b0);

    // W first, AW three cycles later
    wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check1("t3_wready_low", wready, 1'b0);
      check1("t3_awready_high", awready, 1'b1);
      step();
    end
    check1("t3_bvalid_before_aw", bvalid, 1'b0);
    awaddr = 32'h10; awvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0;
    step();
    check1("t3_bvalid", bvalid, 1'b1);
    step();
    bready = 1'b0;
    do_read(32'h10, 0, d, rsp);
    check("t3_readback", d, 32'hDE22_BE44);

    // Backpressure on B and R
    awaddr = 32'h14; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h18; wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check1("t4_bvalid_hold", bvalid, 1'b1);
      check("t4_bresp_hold", 32'(bresp), 32'h0);
      check1("t4_awready_low", awready, 1'b0);
      check1("t4_wready_low", wready, 1'b0);
      step();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    step();
    bready = 1'b0;
    check1("t4_bvalid_cleared", bvalid, 1'b0);
    check1("t4_awready_back", awready, 1'b1);
    araddr = 32'h14; arvalid = 1'b1; rready = 1'b0;
    step();
    araddr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      check1("t4_rvalid_hold", rvalid, 1'b1);
      check("t4_rdata_hold", rdata, 32'hA5A5_A5A5);
      check1("t4_arready_low", arready, 1'b0);
      step();
    end
    arvalid = 1'b0;
    rready = 1'b1;
    step();
    rready = 1'b0;
    check1("t4_rvalid_cleared", rvalid, 1'b0);
    check1("t4_arready_back", arready, 1'b1);

    // Write commit and read sample on the same edge
    do_write(32'h20, 32'h0BAD_C0DE, 4'hF, 0, 0, 0, rsp);
    awaddr = 32'h20; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h20; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    check1("t5_bvalid", bvalid, 1'b1);
    check1("t5_rvalid", rvalid, 1'b1);
    check("t5_old_data", rdata, 32'h0BAD_C0DE);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    do_read(32'h20, 0, d, rsp);
    check("t5_new_data", d, 32'hCAFE_F00D);

    // Vector table: write then read back
    for (int i = 0; i < 7; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, rsp);
      check($sformatf("vec%0d_bresp", i), 32'(rsp), 32'h0);
      do_read(vecs[i].addr, 0, d, rsp);
      check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
    end

    // One past the end of the window
    do_write(BASE, 32'h1234_5678, 4'hF, 0, 0, 0, rsp);
    do_write(BASE + 32'(4 * DEPTH), 32'h8765_4321, 4'hF, 0, 0, 0, rsp);
`ifdef AXIL_SLVERR_EN
    check("t6_bresp_err", 32'(rsp), 32'h2);
    do_read(BASE + 32'(4 * DEPTH), 0, d, rsp);
    check("t6_rresp_err", 32'(rsp), 32'h2);
    check("t6_rdata_zero", d, 32'h0);
    do_read(BASE, 0, d, rsp);
    check("t6_word0_kept", d, 32'h1234_5678);
`else
    check("t6_bresp_ok", 32'(rsp), 32'h0);
    do_read(BASE + 32'(4 * DEPTH), 0, d, rsp);
    check("t6_rresp_ok", 32'(rsp), 32'h0);
    check("t6_alias_read", d, 32'h8765_4321);
    do_read(BASE, 0, d, rsp);
    check("t6_word0_aliased", d, 32'h8765_4321);
`endif

    // Reset with W held: the latched beat is dropped
    do_write(32'h30, 32'h5555_5555, 4'hF, 0, 0, 0, rsp);
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check1("rm_w_held", wready, 1'b0);
    rst = 1'b1;
    #2;
    check1("rm_awready_rst", awready, 1'b0);
    check1("rm_bvalid_rst", bvalid, 1'b0);
    step();
    rst = 1'b0;
    step();
    check1("rm_wready_back", wready, 1'b1);
    check1("rm_bvalid_after", bvalid, 1'b0);
    awaddr = 32'h30; awvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0;
    repeat (3) step();
    check1("rm_no_resp_aw_only", bvalid, 1'b0);
    do_read(32'h30, 0, d, rsp);
    check("rm_no_partial_write", d, 32'h5555_5555);
    wdata = 32'h6666_6666; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    step();
    check1("rm_resp_after_w", bvalid, 1'b1);
    step();
    bready = 1'b0;
    do_read(32'h30, 0, d, rsp);
    check("rm_final", d, 32'h6666_6666);

    // Randomized traffic against the reference model
    for (int k = 0; k < RND_WORDS; k++) begin
      ref_mem[k] = $urandom;
      do_write(RND_BASE + 32'(4 * k), ref_mem[k], 4'hF, 0, 0, 0, rsp);
    end
    for (int n = 0; n < 60; n++) begin
      int unsigned k;
      logic [31:0] a, wd;
      logic [3:0]  st;
      k  = $urandom_range(RND_WORDS - 1, 0);
      a  = RND_BASE + 32'(4 * k) + 32'($urandom_range(3, 0));
      awprot = 3'($urandom); arprot = 3'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        wd = $urandom;
        st = 4'($urandom);
        do_write(a, wd, st, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(2, 0), rsp);
        ref_mem[k] = merge(ref_mem[k], wd, st);
        check($sformatf("rnd%0d_bresp", n), 32'(rsp), 32'h0);
      end else begin
        do_read(a, $urandom_range(3, 0), d, rsp);
        check($sformatf("rnd%0d_rdata", n), d, ref_mem[k]);
      end
    end
    for (int k = 0; k < RND_WORDS; k++) begin
      do_read(RND_BASE + 32'(4 * k), 0, d, rsp);
      check($sformatf("rnd_final%0d", k), d, ref_mem[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
